// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a double-buffered write port.
// The active buffer is replaced from the pending buffer only at frame boundaries or while idle.
module sevenseg_scan_ctrl (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        enable_i,
  input  logic [15:0] presc_i,
  input  logic [3:0]  blank_i,
  input  logic        wr_valid_i,
  input  logic [15:0] wr_data_i,
  input  logic [3:0]  wr_dp_i,
  output logic        wr_ready_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  dig_o,
  output logic        frame_o
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] act_data_q, act_data_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_full_q, pend_full_d;

  logic [6:0]  seg_q;
  logic        dp_q;
  logic [3:0]  dig_q;
  logic        frame_q;

  logic        boundary;
  logic        xfer;
  logic        wr_fire;
  logic        lit_d;
  logic [3:0]  nib_d;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] pick_nibble(input logic [15:0] data, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0: nib = data[3:0];
      2'd1: nib = data[7:4];
      2'd2: nib = data[11:8];
      default: nib = data[15:12];
    endcase
    return nib;
  endfunction

  // Scan sequencing: slot timing, digit advance and frame boundary detection.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;

    case (state_q)
      ST_OFF: begin
        idx_d = 2'd0;
        if (enable_i) begin
          state_d = ST_ON;
          cnt_d   = presc_i;
        end
      end
      ST_ON: begin
        if (cnt_q == 16'd0) begin
          if (blank_i != 4'd0) begin
            state_d = ST_BLANK;
            cnt_d   = {12'd0, blank_i - 4'd1};
          end else begin
            idx_d    = idx_q + 2'd1;
            cnt_d    = presc_i;
            boundary = (idx_q == 2'd3);
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_BLANK: begin
        if (cnt_q == 16'd0) begin
          state_d  = ST_ON;
          idx_d    = idx_q + 2'd1;
          cnt_d    = presc_i;
          boundary = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_OFF;
        idx_d   = 2'd0;
        cnt_d   = 16'd0;
      end
    endcase

    // Disable overrides everything, including a boundary that would otherwise fire.
    if (!enable_i) begin
      state_d  = ST_OFF;
      idx_d    = 2'd0;
      cnt_d    = 16'd0;
      boundary = 1'b0;
    end
  end

  // Buffer handoff; a write is only accepted while pending is empty, so it never collides with a transfer.
  always_comb begin
    wr_fire     = wr_valid_i && !pend_full_q;
    xfer        = pend_full_q && ((state_q == ST_OFF) || boundary);
    act_data_d  = xfer ? pend_data_q : act_data_q;
    act_dp_d    = xfer ? pend_dp_q   : act_dp_q;
    pend_data_d = wr_fire ? wr_data_i : pend_data_q;
    pend_dp_d   = wr_fire ? wr_dp_i   : pend_dp_q;
    if (xfer) begin
      pend_full_d = 1'b0;
    end else if (wr_fire) begin
      pend_full_d = 1'b1;
    end else begin
      pend_full_d = pend_full_q;
    end
    lit_d = (state_d == ST_ON);
    nib_d = pick_nibble(act_data_d, idx_d);
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_OFF;
      idx_q       <= 2'd0;
      cnt_q       <= 16'd0;
      act_data_q  <= 16'd0;
      act_dp_q    <= 4'd0;
      // NOTE: the buffers are plain registers that must read as cleared after reset, so they are reset like any other state.
      pend_data_q <= 16'd0;
      pend_dp_q   <= 4'd0;
      pend_full_q <= 1'b0;
      seg_q       <= 7'd0;
      dp_q        <= 1'b0;
      dig_q       <= 4'd0;
      frame_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of its peers.
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      seg_q       <= lit_d ? hex_decode(nib_d) : 7'd0;
      dp_q        <= lit_d && act_dp_d[idx_d];
      dig_q       <= lit_d ? (4'b0001 << idx_d) : 4'd0;
      frame_q     <= boundary;
    end
  end

  assign wr_ready_o = !pend_full_q;
  assign seg_o      = seg_q;
  assign dp_o       = dp_q;
  assign dig_o      = dig_q;
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench: a slot-plan reference model queues expected per-cycle outputs,
// and a negedge monitor pops and compares them against the scanner.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [15:0] presc_i;
  logic [3:0]  blank_i;
  logic        wr_valid_i;
  logic [15:0] wr_data_i;
  logic [3:0]  wr_dp_i;
  logic        wr_ready_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  dig_o;
  logic        frame_o;

  sevenseg_scan_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .enable_i   (enable_i),
    .presc_i    (presc_i),
    .blank_i    (blank_i),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .wr_dp_i    (wr_dp_i),
    .wr_ready_o (wr_ready_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .dig_o      (dig_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    logic       ready;
  } ent_t;

  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;
  ent_t exp_q[$];
  ent_t mon_e;

  // Reference model: the display is a sequence of slots, each a run of lit cycles
  // followed by a run of dark cycles; whole runs are queued when a slot begins.
  logic [6:0]  dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit          m_on;
  bit          m_in_lit;
  int          m_digit;
  ent_t        plan[$];
  logic [15:0] m_act_data, m_pend_data;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pend_full;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 16'd0, 16'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("dig_o", {12'd0, dig_o}, {12'd0, mon_e.dig});
        check("seg_o", {9'd0, seg_o}, {9'd0, mon_e.seg});
        check("dp_o", {15'd0, dp_o}, {15'd0, mon_e.dp});
        check("frame_o", {15'd0, frame_o}, {15'd0, mon_e.frame});
        check("wr_ready_o", {15'd0, wr_ready_o}, {15'd0, mon_e.ready});
      end
    end
  end

  function automatic ent_t lit_entry(input int d);
    ent_t e;
    logic [15:0] data;
    data    = m_act_data;
    e       = '0;
    e.dig   = 4'(1 << d);
    e.seg   = dec_tbl[data[4*d +: 4]];
    e.dp    = m_act_dp[d];
    return e;
  endfunction

  task automatic model_reset();
    m_on        = 1'b0;
    m_in_lit    = 1'b0;
    m_digit     = 0;
    plan.delete();
    m_act_data  = '0;
    m_act_dp    = '0;
    m_pend_data = '0;
    m_pend_dp   = '0;
    m_pend_full = 1'b0;
  endtask

  // Predict the outputs for the cycle after the coming clock edge from the inputs now applied.
  task automatic model_edge(output ent_t e);
    bit was_off, boundary, start, wr;
    was_off  = !m_on;
    boundary = 1'b0;
    start    = 1'b0;
    wr       = wr_valid_i && !m_pend_full;
    if (!enable_i) begin
      m_on = 1'b0;
      plan.delete();
    end else if (!m_on) begin
      m_on    = 1'b1;
      m_digit = 0;
      start   = 1'b1;
    end else if (plan.size() == 0) begin
      if (m_in_lit && blank_i != 4'd0) begin
        m_in_lit = 1'b0;
        repeat (int'(blank_i)) plan.push_back('0);
      end else begin
        m_digit  = (m_digit + 1) % 4;
        start    = 1'b1;
        boundary = (m_digit == 0);
      end
    end
    if ((was_off || boundary) && m_pend_full) begin
      m_act_data  = m_pend_data;
      m_act_dp    = m_pend_dp;
      m_pend_full = 1'b0;
    end
    if (wr) begin
      m_pend_data = wr_data_i;
      m_pend_dp   = wr_dp_i;
      m_pend_full = 1'b1;
    end
    if (start) begin
      m_in_lit = 1'b1;
      repeat (int'(presc_i) + 1) plan.push_back(lit_entry(m_digit));
      plan[0].frame = boundary;
    end
    e = m_on ? plan.pop_front() : '0;
    e.ready = !m_pend_full;
  endtask

  function automatic bit next_is_boundary();
    return m_on && enable_i && plan.size() == 0 && m_digit == 3 &&
           (!m_in_lit || blank_i == 4'd0);
  endfunction

  task automatic step();
    ent_t e;
    model_edge(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    wr_valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic release_reset();
    ent_t e;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    e       = '0;
    e.ready = 1'b1;
    exp_q.push_back(e);
    mon_en  = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_seg_o", {9'd0, seg_o}, 16'd0);
    check("rst_dig_o", {12'd0, dig_o}, 16'd0);
    check("rst_dp_o", {15'd0, dp_o}, 16'd0);
    check("rst_frame_o", {15'd0, frame_o}, 16'd0);
    check("rst_wr_ready_o", {15'd0, wr_ready_o}, 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int waited;
    rst_n      = 1'b0;
    enable_i   = 1'b0;
    presc_i    = 16'd3;
    blank_i    = 4'd0;
    wr_valid_i = 1'b0;
    wr_data_i  = '0;
    wr_dp_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    release_reset();
    run(3);

    // Enable with cleared data: 1,2,4,8 each 4 cycles, 3F everywhere.
    enable_i = 1'b1;
    run(40);

    // On 2, dark 2.
    presc_i = 16'd1;
    blank_i = 4'd2;
    run(40);

    // First write accepted, the immediate follow-ups are refused while pending is full.
    wr_valid_i = 1'b1;
    wr_data_i  = 16'hF8A1;
    wr_dp_i    = 4'b0100;
    step();
    wr_data_i  = 16'h5555;
    wr_dp_i    = 4'b1111;
    repeat (3) step();
    run(40);

    // Write exactly on the boundary edge: applied one frame later.
    waited = 0;
    wr_valid_i = 1'b0;
    while (!next_is_boundary() && waited < 100) begin
      step();
      waited++;
    end
    check("boundary_wait", {15'd0, next_is_boundary()}, 16'd1);
    wr_valid_i = 1'b1;
    wr_data_i  = 16'h1234;
    wr_dp_i    = 4'b1001;
    step();
    run(40);

    // Minimum slot: one digit per cycle.
    presc_i = 16'd0;
    blank_i = 4'd0;
    run(20);

    // Disable in the middle of a dark gap, then re-enable.
    presc_i = 16'd1;
    blank_i = 4'd3;
    waited  = 0;
    while (!(m_on && !m_in_lit && plan.size() > 0) && waited < 100) begin
      step();
      waited++;
    end
    check("blank_wait", {15'd0, m_in_lit}, 16'd0);
    enable_i = 1'b0;
    run(4);
    enable_i = 1'b1;
    run(30);

    // Asynchronous reset in the middle of a lit slot.
    waited = 0;
    while (!(m_on && m_in_lit && plan.size() > 0) && waited < 100) begin
      step();
      waited++;
    end
    check("on_wait", {15'd0, m_in_lit}, 16'd1);
    mon_en = 1'b0;
    #2;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    release_reset();
    run(20);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      enable_i   = ($urandom_range(0, 63) != 0) ? 1'b1 : (i % 2 == 0);
      if ($urandom_range(0, 7) == 0) presc_i = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) blank_i = 4'($urandom_range(0, 3));
      wr_valid_i = ($urandom_range(0, 4) == 0);
      wr_data_i  = 16'($urandom);
      wr_dp_i    = 4'($urandom);
      step();
    end
    run(2);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
